// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Latency: n/a (declarations only). Backpressure: n/a.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int INC_WORD = 4;
    localparam int INC_HALF = 2;

    localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
    localparam logic [63:0] DEF_TRAP_VECTOR  = 64'h0000_0000_0000_0100;

endpackage

// File: rtl/pc_gen_incrementer.sv
// PC successor adder: pc + 2 or pc + 4, wrapping modulo 2^XLEN.
// Latency: combinational. Backpressure: none.
module pc_incrementer
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            half,
    output logic [XLEN-1:0] link
);

    localparam logic [XLEN-1:0] STEP_WORD = XLEN'(INC_WORD);
    localparam logic [XLEN-1:0] STEP_HALF = XLEN'(INC_HALF);

    assign link = pc + (half ? STEP_HALF : STEP_WORD);

endmodule

// File: rtl/pc_gen_unit.sv
// PC generator with redirect/trap/halt and accepted-fetch counter; `RVC_EN adds 16-bit steps.
// Latency: redirect or advance visible on pc_o one cycle later; first fetch one cycle after reset.
// Backpressure: pc_o held while pc_ready=0; redirect overrides and drops the pending fetch.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR[XLEN-1:0],
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR[XLEN-1:0],
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_ready,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             halt_req,
`ifdef RVC_EN
    input  logic             inst_is_c,
`endif
    output logic [XLEN-1:0]  pc_o,
    output logic             pc_valid,
    output logic [XLEN-1:0]  pc_link,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] fetch_count
);

    state_t           state, state_nxt;
    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  maddr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             mis_nxt;
    logic             half_step;
    logic             target_mis;
    logic             redirect_take;
    logic             fetch;

`ifdef RVC_EN
    assign half_step  = inst_is_c;
    assign target_mis = redirect_target[0];
`else
    assign half_step  = 1'b0;
    assign target_mis = |redirect_target[1:0];
`endif

    pc_incrementer #(.XLEN(XLEN)) u_inc (
        .pc   (pc_o),
        .half (half_step),
        .link (pc_link)
    );

    assign pc_valid      = (state == RUN);
    assign fetch         = pc_valid && pc_ready;
    assign redirect_take = redirect_valid && (state != BOOT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_o;
        maddr_nxt = misalign_addr;
        cnt_nxt   = fetch_count;
        mis_nxt   = 1'b0;

        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt_req)  state_nxt = HALT;
            HALT:    if (!halt_req) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase

        // Redirect beats a same-cycle handshake: the old-PC fetch is discarded uncounted.
        if (redirect_take) begin
            if (target_mis) begin
                pc_nxt    = TRAP_VECTOR;
                mis_nxt   = 1'b1;
                maddr_nxt = redirect_target;
            end else begin
                pc_nxt = redirect_target;
            end
        end else if (fetch) begin
            pc_nxt  = pc_link;
            cnt_nxt = fetch_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc_o          <= RESET_VECTOR;
            misalign_o    <= 1'b0;
            misalign_addr <= '0;
            fetch_count   <= '0;
        end else begin
            state         <= state_nxt;
            pc_o          <= pc_nxt;
            misalign_o    <= mis_nxt;
            misalign_addr <= maddr_nxt;
            fetch_count   <= cnt_nxt;
        end
    end

endmodule
